css_mcu0_dmi_core_to_jtag_rsp: RTL
==================================

CSS_MCU0_DMI_CORE_TO_JTAG_RSP -- requirements
Module: css_mcu0_dmi_core_to_jtag_rsp

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, core cycles allowed for a core response before a failed status is forced; legal range 1..65535.
REQ-002 clk  input  1  core clock; the block's only clock.
REQ-003 rst_n  input  1  core reset; asynchronous assert, active-low.
REQ-004 reg_en  input  1  one-cycle request pulse, already in the clk domain.
REQ-005 reg_wr_en  input  1  qualifies reg_en; 1 = write, 0 = read.
REQ-006 core_rsp_valid  input  1  one-cycle pulse: the core has completed the request.
REQ-007 core_rsp_rdata  input  32  read data; valid only with core_rsp_valid.
REQ-008 core_rsp_err  input  1  error flag; valid only with core_rsp_valid.
REQ-009 jtag_ack  input  1  level signal from the TCK domain, asynchronous to clk.
REQ-010 dmi_clr  input  1  one-cycle pulse; clears the sticky overrun flag.
REQ-011 rsp_done  output  1  level handshake signal to the TCK domain.
REQ-012 rd_data  output  32  held response data.
REQ-013 dmi_stat  output  2  00 = ok, 10 = failed, 11 = overrun.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 jtag_ack shall pass through a 2-flop synchronizer, then be used only as ack_s; a raw jtag_ack transition shall reach ack_s 2 clk edges later.
REQ-016 The FSM shall have exactly four states: IDLE, WAIT_CORE, DONE and WAIT_ACK_LOW.
REQ-017 IDLE -> WAIT_CORE shall occur on reg_en=1 when ack_s=0; this latches reg_wr_en, loads the timeout counter with 0, and clears the last-error flag.
REQ-018 reg_en=1 in IDLE while ack_s=1 shall be dropped and shall set the overrun flag.
REQ-019 In WAIT_CORE, core_rsp_valid=1 shall cause the transition to DONE on the next edge, capturing core_rsp_err into the error flag.
REQ-020 In WAIT_CORE, for a read, rd_data shall load core_rsp_rdata on that same edge; for a write, rd_data shall hold its value.
REQ-021 In WAIT_CORE, the timeout counter shall increment each cycle.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 without core_rsp_valid, the FSM shall go to DONE with the error flag set; for a read, rd_data shall load 0.
REQ-023 If core_rsp_valid and the timeout occur in the same cycle, core_rsp_valid shall win.
REQ-024 rsp_done shall be registered and shall equal 1 exactly while in DONE.
REQ-025 DONE -> WAIT_ACK_LOW shall occur on ack_s=1.
REQ-026 WAIT_ACK_LOW -> IDLE shall occur on ack_s=0.
REQ-027 The handshake shall be 4-phase; rd_data and dmi_stat shall stay stable from DONE entry until the next WAIT_CORE entry.
REQ-028 reg_en=1 in any state other than IDLE shall be ignored and shall set the sticky overrun flag; the FSM, rd_data and the error flag shall be unaffected.
REQ-029 core_rsp_valid outside WAIT_CORE shall be ignored, with no state or flag change.
REQ-030 dmi_stat shall be 11 if overrun=1, else 10 if error=1, else 00.
REQ-031 The overrun flag shall clear only on dmi_clr=1.
REQ-032 If dmi_clr and an overrun-setting reg_en occur in the same cycle, the set shall win.
REQ-033 The timeout counter shall be 16 bits and shall saturate and never wrap.

Reset
REQ-034 On rst_n=0, asynchronously: state = IDLE; rsp_done = 0; busy = 0; rd_data = 32'h0; dmi_stat = 00; overrun = 0; error = 0; counter = 0; both synchronizer flops = 0.
REQ-035 When rst_n is asserted mid-transaction, the block shall discard the transaction; after rst_n is released the block shall issue no rsp_done until a new reg_en is accepted.
REQ-036 Reset release shall be synchronous to clk at the instantiation level; no synchronous reset shall exist.

Verification
REQ-037 Read flow: reg_en=1 with reg_wr_en=0, then core_rsp_valid with rdata=32'hDEADBEEF 5 cycles later -> rsp_done=1 on the following edge, rd_data=DEADBEEF, dmi_stat=00; raise jtag_ack -> rsp_done=0 at 2 edges + 1 cycle; drop jtag_ack -> busy=0.
REQ-038 Write with error: reg_wr_en=1, previous rd_data=32'h12345678, core_rsp_valid with core_rsp_err=1 -> rd_data stays 12345678, dmi_stat=10.
REQ-039 Timeout: TIMEOUT_CYCLES=8, read, no core_rsp_valid -> rsp_done=1 exactly 8 cycles after WAIT_CORE entry, rd_data=0, dmi_stat=10; core_rsp_valid in the 7th cycle instead -> normal completion with dmi_stat=00.
REQ-040 Overrun: reg_en during WAIT_CORE -> dmi_stat=11 at completion; the next transaction still reports 11; dmi_clr pulse -> dmi_stat=00; dmi_clr together with a new overrun -> dmi_stat stays 11.
REQ-041 Reset mid-DONE: rst_n=0 while rsp_done=1 -> all outputs take reset values immediately; after release with jtag_ack held 1, reg_en is dropped and sets overrun.

Source files
------------

// File: rtl/css_mcu0_dmi_core_to_jtag_rsp_if.sv
// rtl/css_mcu0_dmi_core_to_jtag_rsp_if.sv - request/response/handshake bundle between DMI core and JTAG side
interface css_mcu0_dmi_core_to_jtag_rsp_if;
    logic        reg_en;
    logic        reg_wr_en;
    logic        core_rsp_valid;
    logic [31:0] core_rsp_rdata;
    logic        core_rsp_err;
    logic        jtag_ack;
    logic        dmi_clr;
    logic        rsp_done;
    logic [31:0] rd_data;
    logic [1:0]  dmi_stat;
    logic        busy;

    modport master (
        output reg_en, reg_wr_en, core_rsp_valid, core_rsp_rdata, core_rsp_err, jtag_ack, dmi_clr,
        input  rsp_done, rd_data, dmi_stat, busy
    );

    modport slave (
        input  reg_en, reg_wr_en, core_rsp_valid, core_rsp_rdata, core_rsp_err, jtag_ack, dmi_clr,
        output rsp_done, rd_data, dmi_stat, busy
    );
endinterface

// File: rtl/css_mcu0_dmi_core_to_jtag_rsp.sv
// rtl/css_mcu0_dmi_core_to_jtag_rsp.sv - collects a core response and hands it to the TCK domain with a 4-phase handshake
module css_mcu0_dmi_core_to_jtag_rsp #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                          clk,
    input logic                          rst_n,
    css_mcu0_dmi_core_to_jtag_rsp_if.slave dmi
);
    typedef enum logic [1:0] {IDLE, WAIT_CORE, DONE, WAIT_ACK_LOW} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        ack_meta;
    logic        ack_s;
    logic [15:0] cnt;
    logic        wr_q;
    logic        err_q;
    logic        ovr_q;
    logic [31:0] rd_q;
    logic        done_q;
    logic        accept;
    logic        fin_rsp;
    logic        fin_to;
    logic        ovr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= dmi.jtag_ack;
            ack_s    <= ack_meta;
        end
    end

    // A core response in the timeout cycle takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fin_rsp   = 1'b0;
        fin_to    = 1'b0;
        case (state)
            IDLE: begin
                if (dmi.reg_en && !ack_s) begin
                    state_nxt = WAIT_CORE;
                    accept    = 1'b1;
                end
            end
            WAIT_CORE: begin
                if (dmi.core_rsp_valid) begin
                    state_nxt = DONE;
                    fin_rsp   = 1'b1;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = DONE;
                    fin_to    = 1'b1;
                end
            end
            DONE: begin
                if (ack_s) state_nxt = WAIT_ACK_LOW;
            end
            WAIT_ACK_LOW: begin
                if (!ack_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        ovr_set = dmi.reg_en && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 16'h0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
            ovr_q  <= 1'b0;
            rd_q   <= 32'h0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state_nxt == DONE);
            if (accept) begin
                wr_q  <= dmi.reg_wr_en;
                cnt   <= 16'h0;
                err_q <= 1'b0;
            end else if (state == WAIT_CORE && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
            if (fin_rsp) begin
                err_q <= dmi.core_rsp_err;
                if (!wr_q) rd_q <= dmi.core_rsp_rdata;
            end else if (fin_to) begin
                err_q <= 1'b1;
                if (!wr_q) rd_q <= 32'h0;
            end
            // Set beats clear when both land in the same cycle.
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (dmi.dmi_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign dmi.rsp_done = done_q;
    assign dmi.rd_data  = rd_q;
    assign dmi.dmi_stat = ovr_q ? 2'b11 : (err_q ? 2'b10 : 2'b00);
    assign dmi.busy     = (state != IDLE);
endmodule
